alu_cmd_sender: RTL and testbench

- Host-side initiator for the ALU-over-UART protocol: accepts one command (A, B, OPCODE) and serialises it as three bytes through a UART transmitter, in the order A, B, OPCODE.
- Waits for the single result byte from a UART receiver and reports it, or raises a timeout.
- Sits between a local command source (bench driver, board-level controller) and uart_tx / uart_rx instances.

---
 rtl/alu_cmd_sender.sv | 125 ++++++++++++
 tb/tb_alu_cmd_sender.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sender.sv
// alu_cmd_sender: host-side initiator for the ALU-over-UART link.
// Takes one command (A, B, OPCODE) and sends it as three UART bytes in the
// order A, B, OPCODE. It then waits for the single result byte or times out.
module alu_cmd_sender #(
  parameter int NBIT_DATA_LEN  = 8,
  parameter int NBIT_OPCODE    = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [NBIT_DATA_LEN-1:0] a_in,
  input  logic [NBIT_DATA_LEN-1:0] b_in,
  input  logic [NBIT_OPCODE-1:0]   opcode_in,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] tx_data,
  input  logic                     tx_done_tick,
  input  logic                     rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
  output logic [NBIT_DATA_LEN-1:0] result,
  output logic                     result_valid,
  output logic                     timeout,
  output logic                     busy
);

  // The counter only has to reach TIMEOUT_CYCLES-1, because the FSM leaves
  // WAIT_RES at that count. The counter therefore never wraps.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RES} state_t;

  state_t                   state, state_n;
  logic [1:0]               idx, idx_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [NBIT_DATA_LEN-1:0] b_q, b_n;
  logic [NBIT_DATA_LEN-1:0] op_q, op_n;
  logic [NBIT_DATA_LEN-1:0] tx_data_n, result_n;
  logic                     result_valid_n, timeout_n;

  // Outputs that depend only on the state; reset forces IDLE, which drops them at once.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign tx_start  = (state == SEND);

  // Next-state and datapath update logic. Byte A goes straight into tx_data
  // on acceptance, so only B and the opcode need holding registers.
  always_comb begin
    state_n        = state;
    idx_n          = idx;
    cnt_n          = cnt;
    b_n            = b_q;
    op_n           = op_q;
    tx_data_n      = tx_data;
    result_n       = result;
    result_valid_n = 1'b0;
    timeout_n      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n   = SEND;
          idx_n     = 2'd0;
          b_n       = b_in;
          op_n      = NBIT_DATA_LEN'(opcode_in);
          tx_data_n = a_in;
        end
      end
      SEND: begin
        state_n = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done_tick) begin
          if (idx == 2'd2) begin
            state_n = WAIT_RES;
            cnt_n   = '0;
          end else begin
            state_n   = SEND;
            idx_n     = idx + 2'd1;
            tx_data_n = (idx == 2'd0) ? b_q : op_q;
          end
        end
      end
      WAIT_RES: begin
        cnt_n = cnt + 1'b1;
        // When a received byte and the timeout limit fall on the same cycle, the received byte is kept.
        if (rx_done_tick) begin
          result_n       = rx_data_in;
          result_valid_n = 1'b1;
          state_n        = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Register all state; asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= 2'd0;
      cnt          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      tx_data      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      b_q          <= b_n;
      op_q         <= op_n;
      tx_data      <= tx_data_n;
      result       <= result_n;
      result_valid <= result_valid_n;
      timeout      <= timeout_n;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sender.sv
// Directed testbench for alu_cmd_sender with TIMEOUT_CYCLES = 16.
module tb_alu_cmd_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] a_in, b_in;
  logic [5:0] opcode_in;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_tick;
  logic       rx_done_tick;
  logic [7:0] rx_data_in;
  logic [7:0] result;
  logic       result_valid;
  logic       timeout;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;
  int n_start = 0;
  int start_mark;

  alu_cmd_sender #(
    .NBIT_DATA_LEN (8),
    .NBIT_OPCODE   (6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .opcode_in   (opcode_in),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done_tick(tx_done_tick),
    .rx_done_tick(rx_done_tick),
    .rx_data_in  (rx_data_in),
    .result      (result),
    .result_valid(result_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Count tx_start pulses in the middle of each cycle.
  always @(negedge clk) if (tx_start) n_start <= n_start + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge, then scramble the inputs.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    cmd_valid = 1'b1; a_in = a; b_in = b; opcode_in = op;
    chk("ready_before_accept", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; a_in = 8'hEE; b_in = 8'hDD; opcode_in = 6'h15;
  endtask

  // Start in the SEND cycle of one byte and end in the cycle after its
  // tx_done_tick. When spur is set, also drive a tx_done_tick during SEND and
  // an rx_done_tick while waiting; both must be ignored.
  task automatic send_one(input logic [7:0] exp, input bit spur);
    chk("tx_start_pulse", tx_start, 1);
    chk("tx_data_byte", tx_data, exp);
    if (spur) tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("tx_start_low", tx_start, 0);
    chk("tx_data_hold", tx_data, exp);
    repeat (3) step();
    if (spur) begin
      rx_data_in = 8'hFF; rx_done_tick = 1'b1;
      step();
      rx_done_tick = 1'b0;
      chk("spur_rx_no_valid", result_valid, 0);
    end else begin
      step();
    end
    repeat (4) step();
    chk("tx_data_hold_late", tx_data, exp);
    chk("busy_wait_tx", busy, 1);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  // Start in the first WAIT_RES cycle and deliver the result byte after two cycles.
  task automatic finish_rx(input logic [7:0] d);
    repeat (2) step();
    rx_data_in = d; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    chk("result_valid", result_valid, 1);
    chk("result", result, d);
    chk("no_timeout", timeout, 0);
    chk("ready_after_rx", cmd_ready, 1);
    chk("busy_after_rx", busy, 0);
    step();
    chk("result_valid_pulse", result_valid, 0);
    chk("result_hold", result, d);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; a_in = '0; b_in = '0; opcode_in = '0;
    tx_done_tick = 1'b0; rx_done_tick = 1'b0; rx_data_in = '0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {result_valid, timeout}, 0);
    step(); step();
    reset = 1'b1;
    step();
    chk("post_rst_ready", cmd_ready, 1);

    // Basic transaction
    start_mark = n_start;
    accept(8'h05, 8'h03, 6'h20);
    chk("busy_sending", busy, 1);
    chk("ready_low", cmd_ready, 0);
    send_one(8'h05, 1'b0);
    send_one(8'h03, 1'b0);
    send_one(8'h20, 1'b0);
    finish_rx(8'h08);
    chk("three_starts", n_start - start_mark, 3);

    // Timeout with no reply, 16 cycles after entering WAIT_RES
    accept(8'h01, 8'h02, 6'h03);
    send_one(8'h01, 1'b0);
    send_one(8'h02, 1'b0);
    send_one(8'h03, 1'b0);
    repeat (15) step();
    chk("timeout_early", timeout, 0);
    chk("busy_wait_res", busy, 1);
    step();
    chk("timeout_pulse", timeout, 1);
    chk("timeout_no_valid", result_valid, 0);
    chk("timeout_idle", cmd_ready, 1);
    chk("timeout_result_kept", result, 8'h08);
    step();
    chk("timeout_one_cycle", timeout, 0);

    // An rx byte on the final counter cycle is kept, and no timeout is raised
    accept(8'h0A, 8'h0B, 6'h0C);
    send_one(8'h0A, 1'b0);
    send_one(8'h0B, 1'b0);
    send_one(8'h0C, 1'b0);
    repeat (15) step();
    rx_data_in = 8'hAA; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    chk("simul_valid", result_valid, 1);
    chk("simul_result", result, 8'hAA);
    chk("simul_no_timeout", timeout, 0);
    step();
    chk("simul_no_late_timeout", timeout, 0);

    // Spurious ticks in IDLE, in SEND and in WAIT_TX
    start_mark = n_start;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("idle_tx_done_no_start", tx_start, 0);
    chk("idle_tx_done_busy", busy, 0);
    rx_data_in = 8'hFF; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    chk("idle_rx_no_valid", result_valid, 0);
    chk("idle_rx_result", result, 8'hAA);
    accept(8'h11, 8'h22, 6'h33);
    send_one(8'h11, 1'b1);
    send_one(8'h22, 1'b1);
    send_one(8'h33, 1'b1);
    chk("spur_result_kept", result, 8'hAA);
    finish_rx(8'h5A);
    chk("spur_three_starts", n_start - start_mark, 3);

    // Reset in WAIT_TX after byte B has started
    accept(8'h44, 8'h55, 6'h06);
    send_one(8'h44, 1'b0);
    chk("mid_b_data", tx_data, 8'h55);
    step(); step();
    reset = 1'b0;
    #1;
    chk("async_tx_start", tx_start, 0);
    chk("async_tx_data", tx_data, 0);
    chk("async_result", result, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", cmd_ready, 1);
    step(); step();
    reset = 1'b1;
    step();
    chk("rel_ready", cmd_ready, 1);
    chk("rel_flags", {result_valid, timeout, tx_start}, 0);
    accept(8'h66, 8'h77, 6'h08);
    send_one(8'h66, 1'b0);
    send_one(8'h77, 1'b0);
    send_one(8'h08, 1'b0);
    finish_rx(8'h99);

    // Back-to-back commands with cmd_valid held high
    cmd_valid = 1'b1; a_in = 8'h10; b_in = 8'h01; opcode_in = 6'h00;
    step();
    a_in = 8'h7F; b_in = 8'h80; opcode_in = 6'h3F;
    send_one(8'h10, 1'b0);
    send_one(8'h01, 1'b0);
    send_one(8'h00, 1'b0);
    repeat (2) step();
    rx_data_in = 8'h11; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    chk("b2b_valid", result_valid, 1);
    chk("b2b_ready_same_cycle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    send_one(8'h7F, 1'b0);
    send_one(8'h80, 1'b0);
    send_one(8'h3F, 1'b0);
    finish_rx(8'h42);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
